// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg
// Shared definitions for the multicycle CPU (datapath and controller):
// ALU operation codes, mux select encodings, the instruction field layout
// and the register-file geometry.
package mc_cpu_pkg;

    localparam int NREGS = 8;
    localparam int RAW   = $clog2(NREGS);

    // Instruction field bit positions
    localparam int COND_HI = 31, COND_LO = 28;
    localparam int OP_HI   = 27, OP_LO   = 26;
    localparam int FUNC_HI = 25, FUNC_LO = 21;
    localparam int RD_HI   = 20, RD_LO   = 18;
    localparam int RN_HI   = 17, RN_LO   = 15;
    localparam int RM_HI   = 14, RM_LO   = 12;
    localparam int IMM_HI  = 11, IMM_LO  = 0;

    // Same layout as above, as a packed view of the low 32 bits of IR.
    typedef struct packed {
        logic [3:0]     cond;
        logic [1:0]     op;
        logic [4:0]     func;
        logic [RAW-1:0] rd;
        logic [RAW-1:0] rn;
        logic [RAW-1:0] rm;
        logic [11:0]    imm12;
    } instr_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SHL   = 4'd5,
        ALU_SHR   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctl_e;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10,
        SRCB_ZERO = 2'b11
    } alusrcb_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_DATA   = 2'b01,
        RES_ALU    = 2'b10,
        RES_ZERO   = 2'b11
    } ressrc_e;

    typedef enum logic [1:0] {
        IMM_ZX   = 2'b00,
        IMM_SX   = 2'b01,
        IMM_SX4  = 2'b10,
        IMM_ZERO = 2'b11
    } immsrc_e;

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile
// NREGS x XLEN register file: two combinational read ports, one write port
// on the rising edge, synchronous clear on reset. A read of the register
// being written in the same cycle returns the old contents.
// Ports:
//   clk, reset      clock, synchronous active-high clear
//   we, wa, wd      write enable / address / data
//   ra1, ra2        read addresses
//   rd1, rd2        read data
module mc_regfile
    import mc_cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [RAW-1:0]  wa,
    input  logic [XLEN-1:0] wd,
    input  logic [RAW-1:0]  ra1,
    input  logic [RAW-1:0]  ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [NREGS];

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath
// Datapath half of the multicycle CPU: PC, IR, register file, ALU and the
// A/B/ALUOut/Data latches. Executes the control word presented each cycle
// and hands the decoded instruction fields back to the controller.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   ADRSrc..ALUControl              control word from the controller
//   cond, op, func, Rd              decoded IR fields
//   mem_addr/mem_wdata/mem_we       unified memory request
//   mem_rdata                       combinational memory read data
//   pc                              current PC (debug)
module multicycle_datapath
    import mc_cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ADRSrc,
    input  logic            PCWrite,
    input  logic            MemWrite,
    input  logic            IRWrite,
    input  logic            RegWrite,
    input  logic            ALUSrcA,
    input  logic [1:0]      ImmSrc,
    input  logic [1:0]      ALUSrcB,
    input  logic [1:0]      ResultSrc,
    input  logic [1:0]      RegSrc,
    input  logic [3:0]      ALUControl,
    output logic [3:0]      cond,
    output logic [1:0]      op,
    output logic [4:0]      func,
    output logic [2:0]      Rd,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_q, ir_q, a_q, b_q, aluout_q, data_q;
    logic [XLEN-1:0] rd1, rd2, ext_imm, srca, srcb, alu_res, result;
    logic [RAW-1:0]  ra1, ra2;
    logic [4:0]      shamt;
    instr_t          ins;

    assign ins  = instr_t'(ir_q[31:0]);
    assign cond = ins.cond;
    assign op   = ins.op;
    assign func = ins.func;
    assign Rd   = ins.rd;
    assign pc   = pc_q;

    // Register file: RegSrc lets either port read the Rd field (stores read
    // the data register through port 2).
    assign ra1 = RegSrc[0] ? ins.rd : ins.rn;
    assign ra2 = RegSrc[1] ? ins.rd : ins.rm;

    mc_regfile #(.XLEN(XLEN)) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (RegWrite),
        .wa    (ins.rd),
        .wd    (result),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // Immediate extension
    always_comb begin
        ext_imm = '0;
        case (ImmSrc)
            IMM_ZX:  ext_imm = {{(XLEN-12){1'b0}}, ins.imm12};
            IMM_SX:  ext_imm = {{(XLEN-12){ins.imm12[11]}}, ins.imm12};
            IMM_SX4: ext_imm = {{(XLEN-14){ins.imm12[11]}}, ins.imm12, 2'b00};
            default: ext_imm = '0;
        endcase
    end

    // ALU operands
    assign srca = ALUSrcA ? pc_q : a_q;

    always_comb begin
        srcb = '0;
        case (ALUSrcB)
            SRCB_REG:  srcb = b_q;
            SRCB_IMM:  srcb = ext_imm;
            SRCB_FOUR: srcb = XLEN'(4);
            default:   srcb = '0;
        endcase
    end

    assign shamt = srcb[4:0];

    // ALU; unassigned codes yield 0 so unused encodings never leak X.
    always_comb begin
        alu_res = '0;
        case (ALUControl)
            ALU_ADD:   alu_res = srca + srcb;
            ALU_SUB:   alu_res = srca - srcb;
            ALU_AND:   alu_res = srca & srcb;
            ALU_OR:    alu_res = srca | srcb;
            ALU_XOR:   alu_res = srca ^ srcb;
            ALU_SHL:   alu_res = srca << shamt;
            ALU_SHR:   alu_res = srca >> shamt;
            ALU_SRA:   alu_res = $signed(srca) >>> shamt;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, srca < srcb};
            ALU_PASSB: alu_res = srcb;
            default:   alu_res = '0;
        endcase
    end

    // Result bus feeds PC, register write, and (via ADRSrc) the memory address.
    always_comb begin
        result = '0;
        case (ResultSrc)
            RES_ALUOUT: result = aluout_q;
            RES_DATA:   result = data_q;
            RES_ALU:    result = alu_res;
            default:    result = '0;
        endcase
    end

    assign mem_addr  = ADRSrc ? result : pc_q;
    assign mem_wdata = b_q;
    assign mem_we    = MemWrite & ~reset;

    // All right-hand sides are pre-edge values, so a fetch that loads both
    // PC and IR captures the word at the old PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            data_q   <= '0;
        end else begin
            if (PCWrite) pc_q <= result;
            if (IRWrite) ir_q <= mem_rdata;
            a_q      <= rd1;
            b_q      <= rd2;
            aluout_q <= alu_res;
            data_q   <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath with a behavioural unified memory.
module tb_multicycle_datapath;
    logic        clk = 1'b0;
    logic        reset;
    logic        ADRSrc, PCWrite, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ImmSrc, ALUSrcB, ResultSrc, RegSrc;
    logic [3:0]  ALUControl;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [4:0]  func;
    logic [2:0]  Rd;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic        mem_we;

    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;
    int          total = 0, fails = 0;
    int          wr0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[11:2]] = mem_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    multicycle_datapath #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .ADRSrc(ADRSrc), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ImmSrc(ImmSrc), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .RegSrc(RegSrc), .ALUControl(ALUControl),
        .cond(cond), .op(op), .func(func), .Rd(Rd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .pc(pc)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] rd, input logic [2:0] rn,
                                        input logic [2:0] rm, input logic [11:0] imm);
        return {4'h0, 2'b01, 5'h00, rd, rn, rm, imm};
    endfunction

    function automatic logic [31:0] rf(input int r);
        return dut.u_rf.regs[r];
    endfunction

    task automatic idle();
        ADRSrc = 0; PCWrite = 0; MemWrite = 0; IRWrite = 0; RegWrite = 0; ALUSrcA = 0;
        ImmSrc = 0; ALUSrcB = 0; ResultSrc = 0; RegSrc = 0; ALUControl = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FETCH: IR <- mem[PC], PC <- PC + 4
    task automatic fetch(input logic [31:0] instr);
        mem[pc[11:2]] = instr;
        idle();
        IRWrite = 1; PCWrite = 1; ALUSrcA = 1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        tick();
        idle();
    endtask

    // Rd <- ExtImm in one cycle after fetch
    task automatic li(input logic [2:0] rd, input logic [11:0] imm, input logic sx);
        fetch(enc(rd, 3'd0, 3'd0, imm));
        ImmSrc = sx ? 2'b01 : 2'b00; ALUSrcB = 2'b01; ALUControl = 4'd10;
        ResultSrc = 2'b10; RegWrite = 1;
        tick();
        idle();
    endtask

    // fetch, decode, execute, ALU writeback
    task automatic alu_op(input logic [31:0] instr, input logic [1:0] srcb,
                          input logic [1:0] isrc, input logic [3:0] ctl);
        fetch(instr);
        tick();
        ALUSrcA = 0; ALUSrcB = srcb; ImmSrc = isrc; ALUControl = ctl;
        tick();
        idle();
        ResultSrc = 2'b00; RegWrite = 1;
        tick();
        idle();
    endtask

    // Rd <- mem[imm] (absolute address from zero-extended immediate)
    task automatic load_abs(input logic [2:0] rd, input logic [11:0] addr);
        fetch(enc(rd, 3'd0, 3'd0, addr));
        ImmSrc = 2'b00; ALUSrcB = 2'b01; ALUControl = 4'd10; ResultSrc = 2'b10; ADRSrc = 1;
        tick();
        idle();
        ResultSrc = 2'b01; RegWrite = 1;
        tick();
        idle();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h0C0A_4003;
        mem[32'h300 >> 2] = 32'hDEAD_BEEF;
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;

        // reset state
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", dut.ir_q, 32'h0);
        chk("rst_fields", {16'h0, cond, op, func, Rd}, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        for (int i = 0; i < 8; i++) chk($sformatf("rst_r%0d", i), rf(i), 32'h0);

        // reset then fetch
        IRWrite = 1; PCWrite = 1; ALUSrcA = 1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        tick();
        idle();
        chk("fetch_ir", dut.ir_q, 32'h0C0A_4003);
        chk("fetch_pc", pc, 32'h4);
        chk("fetch_op", 32'(op), 32'h3);
        chk("fetch_func", 32'(func), 32'h0);
        chk("fetch_rd", 32'(Rd), 32'h2);

        // R-type ADD
        li(3'd1, 12'd5, 1'b0);
        li(3'd2, 12'd7, 1'b0);
        alu_op(enc(3'd3, 3'd1, 3'd2, 12'h0), 2'b00, 2'b00, 4'd0);
        chk("add_r3", rf(3), 32'd12);
        chk("add_r1", rf(1), 32'd5);
        chk("add_r2", rf(2), 32'd7);

        // I-type SUB with immediate 0xFFF, sign- and zero-extended
        alu_op(enc(3'd6, 3'd1, 3'd0, 12'hFFF), 2'b01, 2'b01, 4'd1);
        chk("subi_sx", rf(6), 32'd6);
        alu_op(enc(3'd7, 3'd1, 3'd0, 12'hFFF), 2'b01, 2'b00, 4'd1);
        chk("subi_zx", rf(7), 32'hFFFF_F006);

        // store R4 at R1+8
        li(3'd1, 12'h200, 1'b0);
        load_abs(3'd4, 12'h300);
        chk("ld_abs_r4", rf(4), 32'hDEAD_BEEF);
        fetch(enc(3'd4, 3'd1, 3'd0, 12'd8));
        RegSrc = 2'b10;
        tick();
        ALUSrcA = 0; ALUSrcB = 2'b01; ImmSrc = 2'b00; ALUControl = 4'd0;
        tick();
        idle();
        RegSrc = 2'b10; ADRSrc = 1; ResultSrc = 2'b00; MemWrite = 1;
        #1;
        chk("st_we", 32'(mem_we), 32'h1);
        chk("st_addr", mem_addr, 32'h208);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("st_we_off", 32'(mem_we), 32'h0);
        chk("st_count", 32'(wr_cnt - wr0), 32'h1);
        chk("st_mem", mem[32'h208 >> 2], 32'hDEAD_BEEF);

        // load from R1+8 into R5
        fetch(enc(3'd5, 3'd1, 3'd0, 12'd8));
        tick();
        ALUSrcA = 0; ALUSrcB = 2'b01; ImmSrc = 2'b00; ALUControl = 4'd0;
        tick();
        idle();
        ADRSrc = 1; ResultSrc = 2'b00;
        tick();
        idle();
        ResultSrc = 2'b01; RegWrite = 1;
        tick();
        idle();
        chk("ld_r5", rf(5), 32'hDEAD_BEEF);
        chk("total_writes", 32'(wr_cnt), 32'h1);

        // boundary: wrap-around add
        li(3'd1, 12'hFFC, 1'b1);
        chk("li_sx", rf(1), 32'hFFFF_FFFC);
        alu_op(enc(3'd2, 3'd1, 3'd0, 12'd4), 2'b01, 2'b00, 4'd0);
        chk("add_wrap", rf(2), 32'h0);

        // boundary: SHL then SRA by 31
        li(3'd3, 12'd1, 1'b0);
        alu_op(enc(3'd3, 3'd3, 3'd0, 12'd31), 2'b01, 2'b00, 4'd5);
        chk("shl31", rf(3), 32'h8000_0000);
        alu_op(enc(3'd4, 3'd3, 3'd0, 12'd31), 2'b01, 2'b00, 4'd7);
        chk("sra31", rf(4), 32'hFFFF_FFFF);

        // boundary: SLT / SLTU of -1 vs 1
        li(3'd5, 12'hFFF, 1'b1);
        li(3'd6, 12'd1, 1'b0);
        alu_op(enc(3'd7, 3'd5, 3'd6, 12'h0), 2'b00, 2'b00, 4'd8);
        chk("slt", rf(7), 32'h1);
        alu_op(enc(3'd7, 3'd5, 3'd6, 12'h0), 2'b00, 2'b00, 4'd9);
        chk("sltu", rf(7), 32'h0);

        // boundary: unused ALU code
        alu_op(enc(3'd3, 3'd6, 3'd0, 12'd5), 2'b01, 2'b00, 4'd15);
        chk("alu15", rf(3), 32'h0);

        // boundary: write and read of R4 in one cycle
        fetch(enc(3'd4, 3'd4, 3'd0, 12'h055));
        ALUSrcB = 2'b01; ImmSrc = 2'b00; ALUControl = 4'd10; ResultSrc = 2'b10; RegWrite = 1;
        tick();
        idle();
        chk("wr_rd_a_old", dut.a_q, 32'hFFFF_FFFF);
        chk("wr_rd_r4", rf(4), 32'h55);
        tick();
        chk("wr_rd_a_new", dut.a_q, 32'h55);

        // reset mid-operation
        wr0 = wr_cnt;
        reset = 1;
        PCWrite = 1; RegWrite = 1; MemWrite = 1; ADRSrc = 1;
        ALUSrcA = 1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        #1;
        chk("midrst_we", 32'(mem_we), 32'h0);
        tick();
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_ir", dut.ir_q, 32'h0);
        chk("midrst_a", dut.a_q, 32'h0);
        for (int i = 0; i < 8; i++) chk($sformatf("midrst_r%0d", i), rf(i), 32'h0);
        chk("midrst_nowrite", 32'(wr_cnt - wr0), 32'h0);
        reset = 0;
        idle();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
